// File: rtl/uart_tx_fifo_pkg.sv
// Shared framing constants and serializer state encoding for the UART transmit path.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;
  // bit_cnt value while the stop bit is being launched, and at its end.
  localparam logic [3:0]  STOP_BIT_CNT    = 4'(UART_FRAME_BITS - 2);
  localparam logic [3:0]  STOP_CNT        = 4'(UART_FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers; read data is combinational.
module sync_fifo #(
  parameter int FIFO_AW = 4,
  parameter int W       = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [FIFO_AW:0] count_o
);

  logic [W-1:0]     mem_q [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO-fed serializer paced by an external clk_div strobe.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DIVIDER = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             baud_en,
  input  logic             baud_pulse,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  // DIVIDER only documents the pairing with clk_div; bit timing comes from baud_pulse.
  if (DIVIDER < 1) begin : g_divider_unsupported
  end

  state_t     state_q;
  logic [7:0] shift_q;
  logic [3:0] bit_cnt_q;
  logic       tx_q, baud_en_q;
  logic       fifo_full, fifo_empty, fifo_pop, frame_end;
  logic [7:0] fifo_rdata;

  assign frame_end = (state_q == ST_SHIFT) && baud_pulse && (bit_cnt_q == STOP_CNT);
  assign fifo_pop  = ~fifo_empty && ((state_q == ST_IDLE) || frame_end);

  assign in_ready = ~fifo_full;
  assign tx       = tx_q;
  assign baud_en  = baud_en_q;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;

  sync_fifo #(.FIFO_AW(FIFO_AW), .W(8)) u_fifo (
    .clk_in  (clk_in),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      baud_en_q <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q      <= 1'b1;
          baud_en_q <= 1'b0;
          if (!fifo_empty) begin
            shift_q   <= fifo_rdata;
            baud_en_q <= 1'b1;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (baud_pulse) begin
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (baud_pulse) begin
            if (bit_cnt_q < STOP_BIT_CNT) begin
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == STOP_BIT_CNT) begin
              tx_q      <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (!fifo_empty) begin
              // Next start bit follows the stop bit with no idle gap.
              shift_q   <= fifo_rdata;
              tx_q      <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              baud_en_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench: a behavioural UART receiver checks every frame against queued pushes.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int BITP = 4;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       baud_en;
  logic       baud_pulse;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  logic       stall, spur;
  logic [1:0] div_cnt = 2'd0;
  int         cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  int         rx_t = 0;
  bit         rx_active = 0;
  logic       cur_bit;
  logic [7:0] rx_byte;

  uart_tx_fifo #(.FIFO_AW(4), .DIVIDER(2)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .baud_en    (baud_en),
    .baud_pulse (baud_pulse),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk_in = ~clk_in;

  // clk_div stand-in: first strobe the cycle after enable rises, then every BITP cycles.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (!baud_en || stall) div_cnt <= 2'd0;
    else                   div_cnt <= div_cnt + 2'd1;
  end
  assign baud_pulse = (baud_en && !stall && div_cnt == 2'd0) || spur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every accepted push joins the expected byte stream.
  initial forever begin
    @(posedge clk_in);
    if (rst === 1'b0 && in_valid && in_ready === 1'b1) exp_q.push_back(in_data);
  end

  // Receiver: frames of 10 bits, each BITP cycles, sampled mid-bit on the falling edge.
  initial forever begin
    @(negedge clk_in);
    if (rst !== 1'b0) begin
      rx_active = 0;
      rx_t = 0;
      exp_q.delete();
    end else begin
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1;
          rx_t = 0;
          frame_starts.push_back(cyc);
        end
      end else begin
        rx_t++;
      end
      if (rx_active) begin
        if (rx_t % BITP == 0) cur_bit = tx;
        else check("bit_hold", {31'd0, tx}, {31'd0, cur_bit});
        if (rx_t % BITP == 2) begin
          if (rx_t / BITP == 0) check("start_bit", {31'd0, tx}, 32'd0);
          else if (rx_t / BITP <= 8) rx_byte[rx_t / BITP - 1] = tx;
          else begin
            check("stop_bit", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0) check("unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
            else check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          end
        end
        if (rx_t == 10 * BITP - 1) rx_active = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("push_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, lows;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; stall = 1'b0; spur = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_baud_en", {31'd0, baud_en}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single byte 0xA5: enable rises one cycle after the push edge.
    push_byte(8'hA5);
    check("a5_en_before", {31'd0, baud_en}, 32'd0);
    tick();
    check("a5_en_rise", {31'd0, baud_en}, 32'd1);
    wait_idle(200);
    check("a5_en_fall", {31'd0, baud_en}, 32'd0);
    check("a5_tx_idle", {31'd0, tx}, 32'd1);
    check("a5_drained", exp_q.size(), 32'd0);

    // Back-to-back frames with no idle gap.
    n0 = frame_starts.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle(300);
    check("b2b_frames", frame_starts.size() - n0, 32'd2);
    if (frame_starts.size() == n0 + 2)
      check("b2b_gap", frame_starts[n0+1] - frame_starts[n0], 10 * BITP);

    // Fill with the line stalled: one byte sits in the shifter, 16 in the FIFO.
    stall = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(8'($urandom));
    check("fill_count", {27'd0, fifo_count}, 32'd16);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    stall = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
    check("fill_ready_back", {31'd0, in_ready}, 32'd1);
    check("fill_count_after_pop", {27'd0, fifo_count}, 32'd15);
    push_byte(8'($urandom));
    wait_idle(1500);
    check("fill_drained", exp_q.size(), 32'd0);

    // Push lands on the same edge as the end-of-stop pop with one byte queued.
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    n = 0;
    while (!(baud_pulse && rx_active && rx_t == 10 * BITP - 2) && n < 200) begin tick(); n++; end
    check("pp_found", {31'd0, n < 200}, 32'd1);
    check("pp_count_before", {27'd0, fifo_count}, 32'd1);
    in_data = 8'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_count_after", {27'd0, fifo_count}, 32'd1);
    wait_idle(300);
    check("pp_drained", exp_q.size(), 32'd0);

    // Spurious strobe while idle.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    check("spur_tx", {31'd0, tx}, 32'd1);
    check("spur_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    check("spur_tx_later", {31'd0, tx}, 32'd1);
    check("spur_baud_en", {31'd0, baud_en}, 32'd0);

    // Reset held two cycles in the middle of a burst.
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    repeat (55) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_baud_en", {31'd0, baud_en}, 32'd0);
    check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("mid_rst_quiet", lows, 32'd0);

    // Random bursts with random gaps.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 50)) tick();
      end
      wait_idle(1000);
    end
    check("final_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
